fifo_rd_fwft: RTL and testbench

FIFO_RD_FWFT -- requirements
Module: fifo_rd_fwft

---
 rtl/fifo_rd_fwft_if.sv | 32 +++
 rtl/fifo_rd_fwft.sv | 81 ++++++++
 tb/tb_fifo_rd_fwft.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_fwft_if.sv
// rtl/fifo_rd_fwft_if.sv - read-side FIFO memory and FWFT consumer handshake bundle
interface fifo_rd_fwft_if #(
    parameter int DATASIZE = 8
);
    logic                rempty;
    logic [DATASIZE-1:0] rdata_mem;
    logic                rinc;
    logic [DATASIZE-1:0] m_data;
    logic                m_valid;
    logic                m_ready;
    logic [1:0]          buf_level;

    modport master (
        input  rempty,
        input  rdata_mem,
        input  m_ready,
        output rinc,
        output m_data,
        output m_valid,
        output buf_level
    );

    modport slave (
        output rempty,
        output rdata_mem,
        output m_ready,
        input  rinc,
        input  m_data,
        input  m_valid,
        input  buf_level
    );
endinterface

// File: rtl/fifo_rd_fwft.sv
// rtl/fifo_rd_fwft.sv - two-entry first-word-fall-through output stage for the read side of a FIFO
module fifo_rd_fwft #(
    parameter int DATASIZE = 8
) (
    input  logic           rclk,
    input  logic           rrst_n,
    fifo_rd_fwft_if.master bus
);

    // Encoding doubles as the buffered word count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATASIZE-1:0] head_q, head_d;
    logic [DATASIZE-1:0] skid_q, skid_d;
    logic                push;
    logic                pop;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = bus.rdata_mem;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = bus.rdata_mem;
                end else if (push) begin
                    skid_d  = bus.rdata_mem;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Push without pop cannot happen here: rinc is held low when full and stalled.
                if (pop) begin
                    head_d = skid_q;
                    if (push) begin
                        skid_d = bus.rdata_mem;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        push = rrst_n && !bus.rempty && ((state_q != ST_FULL) || bus.m_ready);
        pop  = (state_q != ST_EMPTY) && bus.m_ready;
    end

    assign bus.rinc      = push;
    assign bus.m_data    = head_q;
    assign bus.m_valid   = (state_q != ST_EMPTY);
    assign bus.buf_level = state_q;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb/tb_fifo_rd_fwft.sv - self-checking bench for fifo_rd_fwft against a queue model
module tb_fifo_rd_fwft;

    logic rclk;
    logic rrst_n;

    fifo_rd_fwft_if #(.DATASIZE(8)) bus ();

    fifo_rd_fwft #(.DATASIZE(8)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src[$];
    logic [7:0] mq[$];
    logic       stall;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic drive();
        bus.rempty = stall || (src.size() == 0);
        if (src.size() != 0 && !stall) bus.rdata_mem = src[0];
        else                           bus.rdata_mem = 8'($urandom);
        #1;
    endtask

    task automatic tick();
        logic       push;
        logic       pop;
        logic [7:0] w;
        push = rrst_n && !bus.rempty && (mq.size() < 2 || bus.m_ready);
        pop  = (mq.size() != 0) && bus.m_ready;
        w    = bus.rdata_mem;
        @(posedge rclk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(w);
            void'(src.pop_front());
        end
        @(negedge rclk);
        drive();
    endtask

    task automatic test_reset();
        bus.m_ready = 1'b1;
        bus.rempty  = 1'b0;
        bus.rdata_mem = 8'h3C;
        #1;
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
        n_tests++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got %h want 00", bus.m_data); end
        n_tests++; if (bus.buf_level !== 2'd0) begin n_fail++; $display("FAIL reset_buf_level got %0d want 0", bus.buf_level); end
        n_tests++; if (bus.rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc got %b want 0", bus.rinc); end
        @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        stall  = 1'b0;
        src.delete();
        mq.delete();
        drive();
    endtask

    task automatic test_single_word();
        bus.m_ready = 1'b0;
        src.push_back(8'hA5);
        drive();
        n_tests++; if (bus.rinc !== 1'b1) begin n_fail++; $display("FAIL single_rinc got %b want 1", bus.rinc); end
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid got %b want 0", bus.m_valid); end
        tick();
        n_tests++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.m_valid); end
        n_tests++; if (bus.m_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", bus.m_data); end
        n_tests++; if (bus.buf_level !== 2'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", bus.buf_level); end
        n_tests++; if (bus.rinc !== 1'b0) begin n_fail++; $display("FAIL single_rinc_empty got %b want 0", bus.rinc); end
        bus.m_ready = 1'b1;
        drive();
        tick();
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", bus.m_valid); end
    endtask

    task automatic test_fill_backpressure();
        logic exp_rinc[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus.m_ready = 1'b0;
        src.push_back(8'h01);
        src.push_back(8'h02);
        src.push_back(8'h03);
        drive();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (bus.rinc !== exp_rinc[i]) begin n_fail++; $display("FAIL fill_rinc[%0d] got %b want %b", i, bus.rinc, exp_rinc[i]); end
            if (i >= 1) begin
                n_tests++; if (bus.m_data !== 8'h01) begin n_fail++; $display("FAIL fill_head[%0d] got %h want 01", i, bus.m_data); end
            end
            tick();
        end
        n_tests++; if (bus.buf_level !== 2'd2) begin n_fail++; $display("FAIL fill_level got %0d want 2", bus.buf_level); end
        n_tests++; if (bus.m_data !== 8'h01) begin n_fail++; $display("FAIL fill_hold got %h want 01", bus.m_data); end
    endtask

    task automatic test_drain();
        logic [7:0] exp_d[3] = '{8'h01, 8'h02, 8'h03};
        logic [1:0] exp_l[3] = '{2'd2, 2'd2, 2'd1};
        bus.m_ready = 1'b1;
        drive();
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.m_data !== exp_d[i]) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, bus.m_data, exp_d[i]); end
            n_tests++; if (bus.buf_level !== exp_l[i]) begin n_fail++; $display("FAIL drain_level[%0d] got %0d want %0d", i, bus.buf_level, exp_l[i]); end
            tick();
        end
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_valid got %b want 0", bus.m_valid); end
    endtask

    task automatic test_streaming();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) src.push_back(8'(i));
        drive();
        tick();
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got %b/%h want 1/%h", i, bus.m_valid, bus.m_data, 8'(i)); end
            n_tests++; if (bus.buf_level !== 2'd1) begin n_fail++; $display("FAIL stream_level[%0d] got %0d want 1", i, bus.buf_level); end
            tick();
        end
        n_tests++; if (bus.buf_level !== 2'd0) begin n_fail++; $display("FAIL stream_end_level got %0d want 0", bus.buf_level); end
    endtask

    task automatic test_random();
        logic [7:0] exp_words[$];
        int rx = 0;
        int cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            src.push_back(w);
            exp_words.push_back(w);
        end
        while (rx < 1000 && cycles < 20000) begin
            stall       = ($urandom_range(0, 9) < 3);
            bus.m_ready = ($urandom_range(0, 9) < 6);
            drive();
            n_tests++; if (bus.rinc !== (!bus.rempty && (mq.size() < 2 || bus.m_ready))) begin n_fail++; $display("FAIL rand_rinc cyc %0d got %b rempty %b level %0d", cycles, bus.rinc, bus.rempty, mq.size()); end
            n_tests++; if (bus.rinc === 1'b1 && bus.rempty === 1'b1) begin n_fail++; $display("FAIL rand_rinc_empty cyc %0d got rinc 1 want 0", cycles); end
            n_tests++; if (bus.buf_level !== 2'(mq.size()) || bus.buf_level > 2'd2) begin n_fail++; $display("FAIL rand_level cyc %0d got %0d want %0d", cycles, bus.buf_level, mq.size()); end
            n_tests++; if (bus.m_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", cycles, bus.m_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_tests++; if (bus.m_data !== mq[0]) begin n_fail++; $display("FAIL rand_head cyc %0d got %h want %h", cycles, bus.m_data, mq[0]); end
                if (bus.m_ready) begin
                    n_tests++; if (bus.m_data !== exp_words[rx]) begin n_fail++; $display("FAIL rand_order word %0d got %h want %h", rx, bus.m_data, exp_words[rx]); end
                    rx++;
                end
            end
            tick();
            cycles++;
        end
        stall = 1'b0;
        n_tests++; if (rx != 1000) begin n_fail++; $display("FAIL rand_timeout got %0d words want 1000", rx); end
    endtask

    task automatic test_reset_midstream();
        bus.m_ready = 1'b0;
        src.delete();
        mq.delete();
        src.push_back(8'h11);
        src.push_back(8'h22);
        src.push_back(8'h33);
        drive();
        tick();
        tick();
        n_tests++; if (bus.buf_level !== 2'd2) begin n_fail++; $display("FAIL midrst_pre_level got %0d want 2", bus.buf_level); end
        rrst_n = 1'b0;
        #1;
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.m_valid); end
        n_tests++; if (bus.buf_level !== 2'd0) begin n_fail++; $display("FAIL midrst_level got %0d want 0", bus.buf_level); end
        n_tests++; if (bus.rinc !== 1'b0) begin n_fail++; $display("FAIL midrst_rinc got %b want 0", bus.rinc); end
        n_tests++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", bus.m_data); end
        @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        src.delete();
        mq.delete();
        src.push_back(8'h5A);
        drive();
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_release_valid got %b want 0", bus.m_valid); end
        tick();
        n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h5A) begin n_fail++; $display("FAIL midrst_first got %b/%h want 1/5a", bus.m_valid, bus.m_data); end
    endtask

    initial begin
        rrst_n        = 1'b0;
        stall         = 1'b0;
        bus.rempty    = 1'b1;
        bus.rdata_mem = 8'h00;
        bus.m_ready   = 1'b0;
        test_reset();
        test_single_word();
        test_fill_backpressure();
        test_drain();
        test_streaming();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
